// File: rtl/pq_cmd_sequencer.sv
// pq_cmd_sequencer: command front-end for the BRAM heap tree.
// Buffers enqueue/dequeue/replace commands in a small FIFO and issues them
// one at a time to the tree as single-cycle pulses. Each issue is followed
// by a fixed settle gap so the tree's sift finishes before the next one.
// The block also tracks heap occupancy, rejects illegal commands and
// returns the root for dequeue/replace.
module pq_cmd_sequencer #(
    parameter int QUEUE_SIZE = 7,
    parameter int DATA_WIDTH = 16,
    parameter int CMD_DEPTH  = 4,
    parameter int ISSUE_GAP  = 12
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              i_valid,
    input  logic [1:0]                        i_op,
    input  logic [DATA_WIDTH-1:0]             i_data,
    output logic                              o_ready,
    output logic                              o_tree_wrt,
    output logic                              o_tree_read,
    output logic [DATA_WIDTH-1:0]             o_tree_data,
    input  logic [DATA_WIDTH-1:0]             i_tree_data,
    output logic                              o_result_valid,
    output logic [DATA_WIDTH-1:0]             o_result,
    output logic                              o_drop,
    output logic [$clog2(QUEUE_SIZE+1)-1:0]   o_count,
    output logic                              o_full,
    output logic                              o_empty
);

    localparam int AW = $clog2(CMD_DEPTH);
    localparam int CW = $clog2(QUEUE_SIZE+1);
    localparam int GW = $clog2(ISSUE_GAP+1);

    localparam logic [1:0] OP_ENQ = 2'b01;
    localparam logic [1:0] OP_DEQ = 2'b10;
    localparam logic [1:0] OP_REP = 2'b11;

    typedef struct packed {
        logic [1:0]            op;
        logic [DATA_WIDTH-1:0] data;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    cmd_t            fifo_mem [CMD_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            fifo_empty, fifo_full;
    logic            push, pop;
    cmd_t            head;
    state_t          state;
    logic [GW-1:0]   gap_cnt;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign o_ready    = !fifo_full;
    // Opcode 00 is handshaken but never stored.
    assign push       = i_valid && o_ready && (i_op != 2'b00);
    // ISSUE is only entered with a non-empty FIFO, so the pop is always legal.
    assign pop        = (state == ISSUE);
    assign head       = fifo_mem[rd_ptr[AW-1:0]];

    assign o_full  = (o_count == CW'(QUEUE_SIZE));
    assign o_empty = (o_count == '0);

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= '{op: i_op, data: i_data};
    end

    // FIFO pointers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Issue FSM: decode head against current occupancy, drive registered
    // tree pulses for one cycle, then hold off for the settle gap.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= IDLE;
            gap_cnt        <= '0;
            o_tree_wrt     <= 1'b0;
            o_tree_read    <= 1'b0;
            o_tree_data    <= '0;
            o_result_valid <= 1'b0;
            o_result       <= '0;
            o_drop         <= 1'b0;
            o_count        <= '0;
        end else begin
            o_tree_wrt     <= 1'b0;
            o_tree_read    <= 1'b0;
            o_result_valid <= 1'b0;
            o_drop         <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) state <= ISSUE;
                end
                ISSUE: begin
                    gap_cnt <= '0;
                    state   <= GAP;
                    case (head.op)
                        OP_ENQ: begin
                            if (o_full) begin
                                o_drop <= 1'b1;
                            end else begin
                                o_tree_wrt  <= 1'b1;
                                o_tree_data <= head.data;
                                o_count     <= o_count + 1'b1;
                            end
                        end
                        OP_DEQ: begin
                            if (o_empty) begin
                                o_drop <= 1'b1;
                            end else begin
                                o_tree_read    <= 1'b1;
                                o_result       <= i_tree_data;
                                o_result_valid <= 1'b1;
                                o_count        <= o_count - 1'b1;
                            end
                        end
                        OP_REP: begin
                            o_tree_wrt  <= 1'b1;
                            o_tree_data <= head.data;
                            if (o_empty) begin
                                // Nothing to replace: behaves as an enqueue.
                                o_count <= o_count + 1'b1;
                            end else begin
                                o_tree_read    <= 1'b1;
                                o_result       <= i_tree_data;
                                o_result_valid <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                GAP: begin
                    if (gap_cnt == GW'(ISSUE_GAP-1)) begin
                        state <= fifo_empty ? IDLE : ISSUE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pq_cmd_sequencer.sv
// Scoreboard bench for pq_cmd_sequencer: stimulus pushes hand-computed
// expected tree events; a monitor pops and compares on every output pulse.
module tb_pq_cmd_sequencer;

    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          i_valid = 1'b0;
    logic [1:0]    i_op = 2'b00;
    logic [DW-1:0] i_data = '0;
    logic [DW-1:0] i_tree_data = '0;
    logic          o_ready, o_tree_wrt, o_tree_read, o_result_valid, o_drop;
    logic          o_full, o_empty;
    logic [DW-1:0] o_tree_data, o_result;
    logic [2:0]    o_count;

    pq_cmd_sequencer #(.QUEUE_SIZE(7), .DATA_WIDTH(DW), .CMD_DEPTH(4), .ISSUE_GAP(12)) dut (
        .CLK(CLK), .RST(RST), .i_valid(i_valid), .i_op(i_op), .i_data(i_data),
        .o_ready(o_ready), .o_tree_wrt(o_tree_wrt), .o_tree_read(o_tree_read),
        .o_tree_data(o_tree_data), .i_tree_data(i_tree_data),
        .o_result_valid(o_result_valid), .o_result(o_result), .o_drop(o_drop),
        .o_count(o_count), .o_full(o_full), .o_empty(o_empty)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic wrt, rd, drop, rv;
        int   data, res, cnt, dcyc;  // dcyc: spacing from previous event, 0 = don't care
    } evt_t;

    evt_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   stalls;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic evt_t ev(input logic wrt, rd, drop, rv, input int data, res, cnt, dcyc);
        evt_t e;
        e.wrt = wrt; e.rd = rd; e.drop = drop; e.rv = rv;
        e.data = data; e.res = res; e.cnt = cnt; e.dcyc = dcyc;
        return e;
    endfunction

    // Monitor: every output pulse must match the oldest expectation.
    always @(negedge CLK) begin
        if (!RST && (o_tree_wrt || o_tree_read || o_drop || o_result_valid)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 1, 0);
            end else begin
                evt_t e;
                e = exp_q.pop_front();
                chk("tree_wrt", int'(o_tree_wrt), int'(e.wrt));
                chk("tree_read", int'(o_tree_read), int'(e.rd));
                chk("drop", int'(o_drop), int'(e.drop));
                chk("result_valid", int'(o_result_valid), int'(e.rv));
                chk("count", int'(o_count), e.cnt);
                if (e.wrt) chk("tree_data", int'(o_tree_data), e.data);
                if (e.rv)  chk("result", int'(o_result), e.res);
                if (e.dcyc != 0) chk("issue_spacing", cyc - last_cyc, e.dcyc);
            end
            last_cyc = cyc;
        end
    end

    // Present one command from a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [1:0] op, input int data);
        int w;
        i_valid = 1'b1; i_op = op; i_data = DW'(data);
        w = 0;
        while (!o_ready && w < 100) begin
            @(negedge CLK);
            w++;
        end
        if (w >= 100) chk("send_timeout", 1, 0);
        stalls += w;
        @(posedge CLK);
        @(negedge CLK);
        i_valid = 1'b0; i_op = 2'b00;
    endtask

    // Wait for all expected events, then long enough for the FSM to go idle.
    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge CLK);
        chk("drain_pending", exp_q.size(), 0);
        repeat (14) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK); RST = 1'b1;
        @(negedge CLK); @(negedge CLK); RST = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        // Reset state
        chk("rst_ready", int'(o_ready), 1);
        chk("rst_count", int'(o_count), 0);
        chk("rst_empty", int'(o_empty), 1);
        chk("rst_full", int'(o_full), 0);
        chk("rst_tree_data", int'(o_tree_data), 0);
        chk("rst_result", int'(o_result), 0);

        // Back-to-back enqueues, 13-cycle issue spacing
        exp_q.push_back(ev(1, 0, 0, 0, 5, 0, 1, 0));
        exp_q.push_back(ev(1, 0, 0, 0, 3, 0, 2, 13));
        exp_q.push_back(ev(1, 0, 0, 0, 9, 0, 3, 13));
        stalls = 0;
        send(2'b01, 5); send(2'b01, 3); send(2'b01, 9);
        chk("b2b_ready_stalls", stalls, 0);
        drain();
        chk("count_after_3", int'(o_count), 3);

        // Opcode 00 is discarded: no event
        send(2'b00, 77);
        repeat (20) @(negedge CLK);
        chk("nop_count", int'(o_count), 3);

        // Dequeue with root 3
        i_tree_data = 16'd3;
        exp_q.push_back(ev(0, 1, 0, 1, 0, 3, 2, 0));
        send(2'b10, 0);
        drain();

        // Dequeue on empty: drop two cycles after acceptance
        do_reset();
        exp_q.push_back(ev(0, 0, 1, 0, 0, 0, 0, 0));
        send(2'b10, 0);
        @(negedge CLK);
        chk("deq_empty_lat_n1", int'(o_drop), 0);
        @(negedge CLK);
        chk("deq_empty_lat_n2", int'(o_drop), 1);
        chk("deq_empty_noread", int'(o_tree_read), 0);
        // Next command waits out the full gap after the drop
        exp_q.push_back(ev(1, 0, 0, 0, 7, 0, 1, 13));
        send(2'b01, 7);
        // Fill to 7, then one more enqueue is dropped
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(ev(1, 0, 0, 0, 10 + k, 0, 2 + k, 13));
            send(2'b01, 10 + k);
        end
        exp_q.push_back(ev(0, 0, 1, 0, 0, 0, 7, 13));
        send(2'b01, 1);
        drain();
        chk("fill_full", int'(o_full), 1);
        chk("fill_count", int'(o_count), 7);

        // Replace on empty degrades to enqueue; then true replace
        do_reset();
        exp_q.push_back(ev(1, 0, 0, 0, 4, 0, 1, 0));
        send(2'b11, 4);
        drain();
        i_tree_data = 16'd4;
        exp_q.push_back(ev(1, 1, 0, 1, 8, 4, 1, 0));
        send(2'b11, 8);
        drain();

        // Six enqueues with i_valid held: backpressure and FIFO wrap
        do_reset();
        stalls = 0;
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(ev(1, 0, 0, 0, 21 + k, 0, 1 + k, (k == 0) ? 0 : 13));
            send(2'b01, 21 + k);
        end
        chk("backpressure_seen", int'(stalls > 0), 1);
        drain();

        // Asynchronous reset in the middle of GAP abandons the queued command
        exp_q.push_back(ev(1, 0, 0, 0, 30, 0, 7, 0));
        send(2'b01, 30); send(2'b01, 31);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge CLK);
        chk("pre_reset_pending", exp_q.size(), 0);
        repeat (3) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("arst_count", int'(o_count), 0);
        chk("arst_ready", int'(o_ready), 1);
        chk("arst_tree_data", int'(o_tree_data), 0);
        chk("arst_result", int'(o_result), 0);
        chk("arst_empty", int'(o_empty), 1);
        @(negedge CLK); RST = 1'b0;
        repeat (30) @(negedge CLK);
        chk("arst_fifo_flushed", int'(o_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global safety net
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
